ahb_bus_matrix_cmd_master: RTL and testbench

AHB_BUS_MATRIX_CMD_MASTER -- requirements
Module: ahb_bus_matrix_cmd_master

---
 rtl/ahb_bus_matrix_cmd_master_pkg.sv | 41 ++++
 rtl/ahb_bus_matrix_cmd_master_if.sv | 51 +++++
 rtl/ahb_bus_matrix_cmd_master.sv | 148 ++++++++++++++
 tb/tb_ahb_bus_matrix_cmd_master.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_bus_matrix_cmd_master_pkg.sv
// Shared AHB encodings and FSM state type for the command-to-AHB master.
// Latency: n/a (types, constants and an alignment helper only).
// Backpressure: n/a.
package ahb_bus_matrix_pkg;

    // HTRANS encodings; this master only ever drives IDLE or NONSEQ
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // HRESP encodings
    localparam logic [1:0] RSP_OKAY  = 2'b00;
    localparam logic [1:0] RSP_ERROR = 2'b01;
    localparam logic [1:0] RSP_RETRY = 2'b10;
    localparam logic [1:0] RSP_SPLIT = 2'b11;

    // HSIZE encodings supported on a 32-bit bus
    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Fixed transfer attributes: single beat, privileged data access
    localparam logic [2:0] HBURST_SINGLE   = 3'b000;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // A command is legal only if its address is naturally aligned to its size.
    function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            HSIZE_BYTE: return 1'b1;
            HSIZE_HALF: return ~addr_lo[0];
            HSIZE_WORD: return (addr_lo == 2'b00);
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_bus_matrix_cmd_master_if.sv
// Command/response and AHB master signal bundle for ahb_bus_matrix_cmd_master.
// Latency: n/a (wires only).
// Backpressure: cmd_valid/cmd_ready handshake on commands; responses are never stalled.
// Ports: cmd_* (command in), rsp_* (completion out), H* (AHB-Lite master side).
interface ahb_bus_matrix_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // command side
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [2:0]        cmd_size;
    logic [DATA_W-1:0] cmd_wdata;
    // response side
    logic              rsp_valid;
    logic              rsp_error;
    logic [DATA_W-1:0] rsp_rdata;
    logic [7:0]        rsp_waits;
    // AHB bus side
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [3:0]        HPROT;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic [1:0]        HRESP;
    logic [DATA_W-1:0] HRDATA;

    // the master block itself
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_error, rsp_rdata, rsp_waits,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        input  HREADY, HRESP, HRDATA
    );

    // whatever sits opposite: command source plus AHB slave
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_error, rsp_rdata, rsp_waits,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        output HREADY, HRESP, HRDATA
    );

endinterface

// File: rtl/ahb_bus_matrix_cmd_master.sv
// Turns one command at a time into a single non-pipelined AHB transfer and reports completion.
// Latency: rsp_valid 3 cycles after accept with zero waits (1 cycle for a misaligned reject).
// Backpressure: cmd_ready only in IDLE; slave stalls via HREADY; rsp_valid is never held off.
// Ports: HCLK, HRESETn (async active-low), bus (master modport: cmd_*, rsp_*, AHB H* signals).
module ahb_bus_matrix_cmd_master
    import ahb_bus_matrix_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    ahb_bus_matrix_cmd_master_if.master   bus
);

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_haddr;
    logic [1:0]          r_htrans;
    logic                r_hwrite;
    logic [2:0]          r_hsize;
    logic [DATA_W-1:0]   r_hwdata;
    logic [DATA_W-1:0]   r_wdata;      // command write data, parked until the data phase
    logic [7:0]          r_wait_cnt;

    logic                r_rsp_valid;
    logic                r_rsp_error;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic [7:0]          r_rsp_waits;

    logic                w_accept;
    logic                w_aligned;
    logic                w_addr_done;
    logic                w_data_done;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_aligned   = is_aligned(bus.cmd_size, bus.cmd_addr[1:0]);
        w_addr_done = 1'b0;
        w_data_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = bus.cmd_valid;
                // misaligned commands are answered from IDLE without touching the bus
                if (bus.cmd_valid && w_aligned) begin
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // HREADY here belongs to whoever owned the previous data phase;
                // the address is only taken once it is high
                w_addr_done = bus.HREADY;
                if (bus.HREADY) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                w_data_done = bus.HREADY;
                if (bus.HREADY) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Registered bus outputs, wait counter and response
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_haddr     <= '0;
            r_htrans    <= HTRANS_IDLE;
            r_hwrite    <= 1'b0;
            r_hsize     <= 3'b000;
            r_hwdata    <= '0;
            r_wdata     <= '0;
            r_wait_cnt  <= 8'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_waits <= 8'd0;
        end else begin
            r_rsp_valid <= 1'b0;

            if (w_accept) begin
                r_wait_cnt <= 8'd0;
                if (w_aligned) begin
                    r_haddr  <= bus.cmd_addr;
                    r_hwrite <= bus.cmd_write;
                    r_hsize  <= bus.cmd_size;
                    r_wdata  <= bus.cmd_wdata;
                    r_htrans <= HTRANS_NONSEQ;
                end else begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_error <= 1'b1;
                    r_rsp_rdata <= '0;
                    r_rsp_waits <= 8'd0;
                end
            end

            if (w_addr_done) begin
                r_htrans <= HTRANS_IDLE;
                r_hwdata <= r_hwrite ? r_wdata : '0;
            end

            if (r_state == ST_DATA && !bus.HREADY && r_wait_cnt != 8'hFF) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end

            if (w_data_done) begin
                r_hwdata    <= '0;
                r_rsp_valid <= 1'b1;
                // RETRY and SPLIT are not re-issued; they surface as errors
                r_rsp_error <= (bus.HRESP != RSP_OKAY);
                r_rsp_rdata <= r_hwrite ? '0 : bus.HRDATA;
                r_rsp_waits <= r_wait_cnt;
            end
        end
    end

    assign bus.cmd_ready = (r_state == ST_IDLE);
    assign bus.HADDR     = r_haddr;
    assign bus.HTRANS    = r_htrans;
    assign bus.HWRITE    = r_hwrite;
    assign bus.HSIZE     = r_hsize;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HPROT     = HPROT_DATA_PRIV;
    assign bus.HWDATA    = r_hwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_error = r_rsp_error;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_waits = r_rsp_waits;

endmodule

// File: tb/tb_ahb_bus_matrix_cmd_master.sv
// Directed bench for ahb_bus_matrix_cmd_master: vector table plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: bench plays the AHB slave and drives HREADY per cycle.
module tb_ahb_bus_matrix_cmd_master;
    import ahb_bus_matrix_pkg::*;

    logic HCLK;
    logic HRESETn;

    int n_cmp;
    int n_err;

    ahb_bus_matrix_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ahb_bus_matrix_cmd_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus.master)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int          addr_waits;   // HREADY low cycles while in the address phase
        int          data_waits;   // HREADY low cycles in the data phase
        logic [1:0]  hresp;
        logic [31:0] rdata;
        logic        misal;        // expect immediate reject, no bus transfer
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_waits;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one command and plays the slave; all sampling on the falling edge.
    task automatic do_cmd(input vec_t v, input string tag);
        logic [31:0] exp_hwdata;
        @(negedge HCLK);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = v.wr;
        bus.cmd_addr  = v.addr;
        bus.cmd_size  = v.size;
        bus.cmd_wdata = v.wdata;
        @(negedge HCLK);
        bus.cmd_valid = 1'b0;
        if (v.misal) begin
            chk({tag, "_rej_htrans"}, 32'(bus.HTRANS), 32'(HTRANS_IDLE));
            chk({tag, "_rej_valid"},  32'(bus.rsp_valid), 32'd1);
            chk({tag, "_rej_error"},  32'(bus.rsp_error), 32'd1);
            chk({tag, "_rej_waits"},  32'(bus.rsp_waits), 32'd0);
            @(negedge HCLK);
            chk({tag, "_rej_pulse"},  32'(bus.rsp_valid), 32'd0);
            chk({tag, "_rej_idle"},   32'(bus.HTRANS), 32'(HTRANS_IDLE));
            return;
        end
        chk({tag, "_htrans_ns"}, 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
        chk({tag, "_haddr"},     bus.HADDR, v.addr);
        chk({tag, "_hwrite"},    32'(bus.HWRITE), 32'(v.wr));
        chk({tag, "_hsize"},     32'(bus.HSIZE), 32'(v.size));
        chk({tag, "_hburst"},    32'(bus.HBURST), 32'd0);
        chk({tag, "_hprot"},     32'(bus.HPROT), 32'd3);
        for (int i = 0; i < v.addr_waits; i++) begin
            bus.HREADY = 1'b0;
            @(negedge HCLK);
            chk({tag, "_aw_htrans"}, 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
            chk({tag, "_aw_haddr"},  bus.HADDR, v.addr);
        end
        bus.HREADY = 1'b1;
        bus.HRESP  = RSP_OKAY;
        @(negedge HCLK);
        chk({tag, "_dp_htrans"}, 32'(bus.HTRANS), 32'(HTRANS_IDLE));
        exp_hwdata = v.wr ? v.wdata : 32'h0;
        for (int i = 0; i < v.data_waits; i++) begin
            bus.HREADY = 1'b0;
            bus.HRESP  = (i == v.data_waits - 1) ? v.hresp : RSP_OKAY;
            bus.HRDATA = 32'hBAD0_BAD0;
            chk({tag, "_dw_hwdata"}, bus.HWDATA, exp_hwdata);
            chk({tag, "_dw_valid"},  32'(bus.rsp_valid), 32'd0);
            @(negedge HCLK);
        end
        bus.HREADY = 1'b1;
        bus.HRESP  = v.hresp;
        bus.HRDATA = v.rdata;
        chk({tag, "_dl_hwdata"}, bus.HWDATA, exp_hwdata);
        chk({tag, "_dl_valid"},  32'(bus.rsp_valid), 32'd0);
        @(negedge HCLK);
        bus.HRESP  = RSP_OKAY;
        bus.HRDATA = 32'hBAD0_BAD0;
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "_rsp_error"}, 32'(bus.rsp_error), 32'(v.exp_err));
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, v.exp_rdata);
        chk({tag, "_rsp_waits"}, 32'(bus.rsp_waits), 32'(v.exp_waits));
        chk({tag, "_rsp_ready"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, "_rsp_hwdata"}, bus.HWDATA, 32'h0);
        @(negedge HCLK);
        chk({tag, "_pulse"},      32'(bus.rsp_valid), 32'd0);
        chk({tag, "_hold_rdata"}, bus.rsp_rdata, v.exp_rdata);
        chk({tag, "_hold_waits"}, 32'(bus.rsp_waits), 32'(v.exp_waits));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_htrans"},    32'(bus.HTRANS), 32'd0);
        chk({tag, "_haddr"},     bus.HADDR, 32'h0);
        chk({tag, "_hwrite"},    32'(bus.HWRITE), 32'd0);
        chk({tag, "_hsize"},     32'(bus.HSIZE), 32'd0);
        chk({tag, "_hwdata"},    bus.HWDATA, 32'h0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_error"}, 32'(bus.rsp_error), 32'd0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
        chk({tag, "_rsp_waits"}, 32'(bus.rsp_waits), 32'd0);
        chk({tag, "_hburst"},    32'(bus.HBURST), 32'd0);
        chk({tag, "_hprot"},     32'(bus.HPROT), 32'd3);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        //              wr   addr           sz  wdata          aw dw   hresp      rdata          mis err exp_rdata      waits
        vecs[0]  = '{1'b0, 32'h0000_1004, 3'd2, 32'h0,         0, 0,   RSP_OKAY,  32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, 8'd0};
        vecs[1]  = '{1'b1, 32'h0000_0020, 3'd2, 32'h1234_5678, 0, 3,   RSP_OKAY,  32'h0,         1'b0, 1'b0, 32'h0,         8'd3};
        vecs[2]  = '{1'b0, 32'hF000_0000, 3'd2, 32'h0,         0, 1,   RSP_ERROR, 32'h0,         1'b0, 1'b1, 32'h0,         8'd1};
        vecs[3]  = '{1'b0, 32'h0000_0003, 3'd2, 32'h0,         0, 0,   RSP_OKAY,  32'h0,         1'b1, 1'b1, 32'h0,         8'd0};
        vecs[4]  = '{1'b0, 32'h0000_0010, 3'd2, 32'h0,         0, 300, RSP_OKAY,  32'hA5A5_A5A5, 1'b0, 1'b0, 32'hA5A5_A5A5, 8'd255};
        vecs[5]  = '{1'b1, 32'h0000_0007, 3'd0, 32'h0000_00AB, 0, 1,   RSP_RETRY, 32'h0,         1'b0, 1'b1, 32'h0,         8'd1};
        vecs[6]  = '{1'b0, 32'h0000_0002, 3'd1, 32'h0,         0, 2,   RSP_SPLIT, 32'h0000_BEEF, 1'b0, 1'b1, 32'h0000_BEEF, 8'd2};
        vecs[7]  = '{1'b1, 32'h0000_0005, 3'd1, 32'h0000_1111, 0, 0,   RSP_OKAY,  32'h0,         1'b1, 1'b1, 32'h0,         8'd0};
        vecs[8]  = '{1'b0, 32'h0000_0000, 3'd3, 32'h0,         0, 0,   RSP_OKAY,  32'h0,         1'b1, 1'b1, 32'h0,         8'd0};
        vecs[9]  = '{1'b1, 32'h0000_0044, 3'd2, 32'h55AA_55AA, 2, 0,   RSP_OKAY,  32'h0,         1'b0, 1'b0, 32'h0,         8'd0};
        vecs[10] = '{1'b0, 32'h0000_0080, 3'd2, 32'h0,         0, 254, RSP_OKAY,  32'h0102_0304, 1'b0, 1'b0, 32'h0102_0304, 8'd254};
        vecs[11] = '{1'b0, 32'h0000_0084, 3'd2, 32'h0,         0, 255, RSP_OKAY,  32'h0506_0708, 1'b0, 1'b0, 32'h0506_0708, 8'd255};

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_size  = 3'd0;
        bus.cmd_wdata = 32'h0;
        bus.HREADY    = 1'b1;
        bus.HRESP     = RSP_OKAY;
        bus.HRDATA    = 32'h0;
        HRESETn       = 1'b0;
        #1;
        chk_reset_vals("por");
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk("por_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        for (int k = 0; k < NVEC; k++) begin
            do_cmd(vecs[k], $sformatf("v%0d", k));
        end

        // Back-to-back: second command offered in the response cycle of the first
        @(negedge HCLK);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h100;
        bus.cmd_size = HSIZE_WORD; bus.cmd_wdata = 32'h0;
        @(negedge HCLK);
        bus.cmd_valid = 1'b0;
        chk("b2b_a_ns", 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
        @(negedge HCLK);
        bus.HRDATA = 32'h1111_1111;
        @(negedge HCLK);
        chk("b2b_a_valid", 32'(bus.rsp_valid), 32'd1);
        chk("b2b_a_rdata", bus.rsp_rdata, 32'h1111_1111);
        chk("b2b_ready",   32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1; bus.cmd_addr = 32'h104;
        bus.HRDATA = 32'hBAD0_BAD0;
        @(negedge HCLK);
        bus.cmd_valid = 1'b0;
        chk("b2b_b_ns",    32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
        chk("b2b_b_haddr", bus.HADDR, 32'h104);
        chk("b2b_b_pulse", 32'(bus.rsp_valid), 32'd0);
        @(negedge HCLK);
        bus.HRDATA = 32'h2222_2222;
        @(negedge HCLK);
        chk("b2b_b_valid", 32'(bus.rsp_valid), 32'd1);
        chk("b2b_b_rdata", bus.rsp_rdata, 32'h2222_2222);

        // Reset asserted while the data phase is stalled
        @(negedge HCLK);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'h40;
        bus.cmd_size = HSIZE_WORD; bus.cmd_wdata = 32'hCAFE_F00D;
        @(negedge HCLK);
        bus.cmd_valid = 1'b0;
        @(negedge HCLK);
        bus.HREADY = 1'b0;
        @(negedge HCLK);
        chk("rst_pre_hwdata", bus.HWDATA, 32'hCAFE_F00D);
        HRESETn = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        bus.HREADY = 1'b1;
        @(negedge HCLK);
        chk("rst_hold_valid", 32'(bus.rsp_valid), 32'd0);
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk("rst_rel_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rel_ready", 32'(bus.cmd_ready), 32'd1);
        do_cmd(vecs[1], "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
